// File: rtl/nic_filter_sched_if.sv
// Bundle of all signals between the scheduler, the connection block and the filter engines.
// master = scheduler side, slave = connection block plus engines.
interface nic_filter_sched_if #(
    parameter int N_ENG  = 4,
    parameter int DROP_W = 3
);
    logic              receiving;
    logic [1:0]        byte_offset;
    logic [4:0]        word_offset;
    logic [N_ENG-1:0]  eng_start;
    logic [N_ENG-1:0]  eng_req;
    logic [N_ENG*5-1:0] eng_addr;
    logic [N_ENG-1:0]  eng_gnt;
    logic [4:0]        buf_addr;
    logic [N_ENG-1:0]  eng_done;
    logic [N_ENG-1:0]  eng_drop;
    logic              done;
    logic [DROP_W-1:0] drop_pkg;
    logic              tx_init;
    logic              busy;
    logic              overrun;
    logic [2:0]        fsm_state;

    modport master (
        input  receiving, byte_offset, word_offset, eng_req, eng_addr,
               eng_done, eng_drop, tx_init,
        output eng_start, eng_gnt, buf_addr, done, drop_pkg, busy, overrun, fsm_state
    );

    modport slave (
        output receiving, byte_offset, word_offset, eng_req, eng_addr,
               eng_done, eng_drop, tx_init,
        input  eng_start, eng_gnt, buf_addr, done, drop_pkg, busy, overrun, fsm_state
    );
endinterface

// File: rtl/nic_filter_sched.sv
// Packet-inspection sequencer: starts all filter engines at end of receive, round-robins the
// packet-buffer read port among them, and merges their verdicts for the TX side.
module nic_filter_sched #(
    parameter int N_ENG     = 4,
    parameter int PKT_WORDS = 20,
    parameter int TIMEOUT   = 255,
    parameter int DROP_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    nic_filter_sched_if.master bus
);
    localparam int IW = (N_ENG > 1) ? $clog2(N_ENG) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        RUN     = 3'd2,
        VERDICT = 3'd3,
        HOLD    = 3'd4,
        CLEAR   = 3'd5
    } state_t;

    state_t            state, state_next;
    logic              pkt_end;
    logic [N_ENG-1:0]  done_vec, drop_vec, done_now, newly_done, req_masked;
    logic              all_done;
    logic [TW-1:0]     timer;
    logic              timeout_flag;
    logic [IW-1:0]     rr;
    logic [IW-1:0]     win_idx, hi_idx, any_idx;
    logic              win_found, hi_found, any_found;
    logic [N_ENG-1:0]  gnt_q;
    logic [4:0]        buf_addr_q;
    logic [DROP_W-1:0] drop_pkg_q, verdict_code;
    logic              overrun_q;
    logic [N_ENG-1:0]  eng_start_w;
    logic              done_w, busy_w;

    assign pkt_end    = bus.receiving && (bus.word_offset == 5'(PKT_WORDS - 1))
                        && (bus.byte_offset == 2'd3);
    assign done_now   = done_vec | bus.eng_done;
    assign newly_done = bus.eng_done & ~done_vec;
    assign all_done   = &done_now;
    assign req_masked = bus.eng_req & ~done_now;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pkt_end) state_next = START;
            START:   state_next = RUN;
            RUN:     if (all_done || (timer == TW'(TIMEOUT - 1))) state_next = VERDICT;
            VERDICT: state_next = HOLD;
            HOLD:    if (bus.tx_init) state_next = CLEAR;
            CLEAR:   if (!bus.tx_init) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Moore outputs decoded from the state register
    always_comb begin
        eng_start_w = '0;
        done_w      = 1'b0;
        busy_w      = (state != IDLE);
        case (state)
            START:   eng_start_w = '1;
            HOLD:    done_w      = 1'b1;
            default: ;
        endcase
    end

    // Round-robin pick: lowest masked requester at/after rr, else lowest overall (wrap)
    always_comb begin
        hi_found  = 1'b0;
        hi_idx    = '0;
        any_found = 1'b0;
        any_idx   = '0;
        for (int i = N_ENG - 1; i >= 0; i--) begin
            if (req_masked[i]) begin
                any_found = 1'b1;
                any_idx   = IW'(i);
                if (i >= int'(rr)) begin
                    hi_found = 1'b1;
                    hi_idx   = IW'(i);
                end
            end
        end
        win_found = any_found;
        win_idx   = hi_found ? hi_idx : any_idx;
    end

    always_comb begin
        verdict_code = '0;
        if (timeout_flag) begin
            verdict_code = DROP_W'(7);
        end else begin
            for (int k = N_ENG - 1; k >= 0; k--) begin
                if (drop_vec[k]) verdict_code = DROP_W'(k + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_vec     <= '0;
            drop_vec     <= '0;
            timer        <= '0;
            timeout_flag <= 1'b0;
            rr           <= '0;
            gnt_q        <= '0;
            buf_addr_q   <= '0;
            drop_pkg_q   <= '0;
            overrun_q    <= 1'b0;
        end else begin
            if (pkt_end && (state != IDLE)) overrun_q <= 1'b1;
            gnt_q <= '0;
            case (state)
                START: begin
                    done_vec     <= '0;
                    drop_vec     <= '0;
                    timer        <= '0;
                    timeout_flag <= 1'b0;
                end
                RUN: begin
                    done_vec     <= done_now;
                    drop_vec     <= (drop_vec & ~newly_done) | (bus.eng_drop & newly_done);
                    timer        <= timer + 1'b1;
                    timeout_flag <= !all_done && (timer == TW'(TIMEOUT - 1));
                    // A grant issued on the RUN exit edge would land outside RUN, so suppress it
                    if (win_found && (state_next == RUN)) begin
                        gnt_q      <= N_ENG'(1) << win_idx;
                        buf_addr_q <= bus.eng_addr[int'(win_idx)*5 +: 5];
                        rr         <= (win_idx == IW'(N_ENG - 1)) ? '0 : win_idx + 1'b1;
                    end
                end
                VERDICT: drop_pkg_q <= verdict_code;
                default: ;
            endcase
        end
    end

    assign bus.eng_start = eng_start_w;
    assign bus.eng_gnt   = gnt_q;
    assign bus.buf_addr  = buf_addr_q;
    assign bus.done      = done_w;
    assign bus.drop_pkg  = drop_pkg_q;
    assign bus.busy      = busy_w;
    assign bus.overrun   = overrun_q;
    assign bus.fsm_state = state;
endmodule

// File: tb/tb_nic_filter_sched.sv
// Randomized bench for nic_filter_sched: packets with scripted engine timing, checked each
// cycle against a timeline/round-robin reference model.
module tb_nic_filter_sched;
    localparam int N     = 4;
    localparam int R     = 2;      // first RUN cycle, counted from the pkt_end cycle
    localparam int NEVER = 1000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nic_filter_sched_if #(.N_ENG(N), .DROP_W(3)) bus ();

    nic_filter_sched #(.N_ENG(N), .PKT_WORDS(20), .TIMEOUT(255), .DROP_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // reference model state
    int           m_rr;
    logic [N-1:0] m_gnt;
    logic [4:0]   m_buf;
    logic [2:0]   m_pkg;
    logic         m_ovr;
    logic [N-1:0] prev_done, prev_drop;

    // packet configuration
    int           cfg_d[N];
    logic [N-1:0] cfg_drop;
    bit           cfg_allreq;
    int           cfg_h, cfg_l, cfg_gap;
    int           cfg_ovr_sel;    // 0 none, 1 random busy cycle, 2 first HOLD cycle
    int           cfg_abort_sel;  // 0 none, 1 mid RUN, 2 together with pkt_end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_all(input logic [N-1:0] e_start, input logic [N-1:0] e_gnt,
                             input logic [4:0] e_buf, input logic e_done, input logic [2:0] e_pkg,
                             input logic e_busy, input logic e_ovr);
        check("eng_start", 32'(bus.eng_start), 32'(e_start));
        check("eng_gnt",   32'(bus.eng_gnt),   32'(e_gnt));
        check("buf_addr",  32'(bus.buf_addr),  32'(e_buf));
        check("done",      32'(bus.done),      32'(e_done));
        check("drop_pkg",  32'(bus.drop_pkg),  32'(e_pkg));
        check("busy",      32'(bus.busy),      32'(e_busy));
        check("overrun",   32'(bus.overrun),   32'(e_ovr));
    endtask

    task automatic model_reset();
        m_rr = 0; m_gnt = '0; m_buf = '0; m_pkg = '0; m_ovr = 1'b0;
        prev_done = '0; prev_drop = '0;
    endtask

    task automatic drive_noise();
        bus.receiving   = 1'($urandom_range(0, 1));
        bus.word_offset = 5'($urandom_range(0, 19));
        bus.byte_offset = (bus.word_offset == 5'd19) ? 2'($urandom_range(0, 2))
                                                     : 2'($urandom_range(0, 3));
    endtask

    task automatic cfg_random();
        for (int k = 0; k < N; k++) begin
            cfg_d[k]    = $urandom_range(0, 30);
            cfg_drop[k] = ($urandom_range(0, 3) == 0);
        end
        if ($urandom_range(0, 7) == 0) cfg_d[$urandom_range(0, N-1)] = NEVER;
        cfg_allreq    = 1'b0;
        cfg_h         = $urandom_range(0, 3);
        cfg_l         = $urandom_range(1, 3);
        cfg_gap       = $urandom_range(1, 4);
        cfg_ovr_sel   = ($urandom_range(0, 3) == 0) ? 1 : 0;
        cfg_abort_sel = 0;
    endtask

    task automatic run_packet();
        int maxd, v, hold_end, busy_end, last_cyc, ovr_at, abort_at, w;
        logic [2:0]   new_pkg;
        logic [N-1:0] done_t, req_t, mreq;
        logic [4:0]   addr_t[N];
        maxd = 0;
        for (int k = 0; k < N; k++) if (cfg_d[k] > maxd) maxd = cfg_d[k];
        if (maxd <= 254) begin
            v = R + maxd + 1;
            new_pkg = 3'd0;
            for (int k = N - 1; k >= 0; k--) if (cfg_drop[k]) new_pkg = 3'(k + 1);
        end else begin
            v = R + 255;
            new_pkg = 3'd7;
        end
        hold_end = v + 1 + cfg_h;
        busy_end = hold_end + cfg_l;
        last_cyc = busy_end + cfg_gap;
        ovr_at   = (cfg_ovr_sel == 1) ? $urandom_range(1, busy_end) :
                   (cfg_ovr_sel == 2) ? v + 1 : -1;
        abort_at = (cfg_abort_sel == 1) ? R + (v - R) / 2 :
                   (cfg_abort_sel == 2) ? 0 : -1;
        for (int c = 0; c <= last_cyc; c++) begin
            @(posedge clk); #1;
            cyc++;
            rst = (c == abort_at);
            if (c == 0 || c == ovr_at) begin
                bus.receiving = 1'b1; bus.word_offset = 5'd19; bus.byte_offset = 2'd3;
            end else begin
                drive_noise();
            end
            for (int k = 0; k < N; k++) begin
                done_t[k]    = (c <= 1) ? prev_done[k] : (c >= R + cfg_d[k]);
                addr_t[k]    = 5'($urandom_range(0, 31));
                req_t[k]     = cfg_allreq ? 1'b1 : 1'($urandom_range(0, 1));
                bus.eng_drop[k] = (c <= 1) ? prev_drop[k] :
                                  done_t[k] ? cfg_drop[k] : 1'($urandom_range(0, 1));
                bus.eng_addr[k*5 +: 5] = addr_t[k];
            end
            bus.eng_done = done_t;
            bus.eng_req  = req_t;
            bus.tx_init  = (c >= hold_end) && (c < busy_end);
            @(negedge clk);
            if (abort_at >= 0 && c == abort_at + 1) begin
                model_reset();
                check_all('0, '0, '0, 1'b0, 3'd0, 1'b0, 1'b0);
                break;
            end
            if (c == v + 1) m_pkg = new_pkg;
            if (ovr_at >= 1 && c == ovr_at + 1) m_ovr = 1'b1;
            check_all((c == 1) ? '1 : '0, m_gnt, m_buf, (c >= v + 1) && (c <= hold_end),
                      m_pkg, (c >= 1) && (c <= busy_end), m_ovr);
            m_gnt = '0;
            if (c >= R && c + 1 < v) begin
                mreq = req_t & ~done_t;
                w = -1;
                for (int i = 0; i < N; i++)
                    if (w < 0 && mreq[(m_rr + i) % N]) w = (m_rr + i) % N;
                if (w >= 0) begin
                    m_gnt = N'(1) << w;
                    m_buf = addr_t[w];
                    m_rr  = (w + 1) % N;
                end
            end
        end
        rst = 1'b0;
        if (abort_at < 0) begin
            for (int k = 0; k < N; k++) prev_done[k] = (last_cyc >= R + cfg_d[k]);
            prev_drop = cfg_drop;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.receiving = 1'b0; bus.word_offset = '0; bus.byte_offset = '0;
        bus.eng_req = '0; bus.eng_addr = '0; bus.eng_done = '0; bus.eng_drop = '0;
        bus.tx_init = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_all('0, '0, '0, 1'b0, 3'd0, 1'b0, 1'b0);
        check("fsm_state_idle", 32'(bus.fsm_state), 32'd0);

        // round-robin with every engine requesting, rr starting at 0, clean pass
        cfg_random();
        for (int k = 0; k < N; k++) cfg_d[k] = 12;
        cfg_drop = '0; cfg_allreq = 1'b1; cfg_ovr_sel = 0;
        run_packet();
        // engines 1 and 3 drop -> 2
        cfg_random(); cfg_drop = 4'b1010; cfg_ovr_sel = 0; run_packet();
        // engine 0 alone drops -> 1
        cfg_random(); cfg_drop = 4'b0001; cfg_ovr_sel = 0; run_packet();
        // engine 2 never finishes -> timeout verdict 7
        cfg_random(); cfg_d[2] = NEVER; cfg_ovr_sel = 0; run_packet();
        // last engine finishes in the final cycle before timeout -> real verdict
        cfg_random(); cfg_d[2] = 254; cfg_drop = 4'b0100; cfg_ovr_sel = 0; run_packet();
        // second pkt_end during HOLD
        cfg_random(); cfg_ovr_sel = 2; run_packet();
        // reset mid RUN with grants active, then a normal packet
        cfg_random(); for (int k = 0; k < N; k++) cfg_d[k] = 20;
        cfg_allreq = 1'b1; cfg_ovr_sel = 0; cfg_abort_sel = 1; run_packet();
        cfg_random(); cfg_ovr_sel = 0; run_packet();
        // reset coinciding with pkt_end
        cfg_random(); cfg_ovr_sel = 0; cfg_abort_sel = 2; run_packet();
        for (int p = 0; p < 24; p++) begin
            cfg_random();
            run_packet();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
